// File: rtl/air_hockey_puck_pkg.sv
// rtl/air_hockey_puck_pkg.sv - shared geometry, colours and state encodings for the puck stage
package air_hockey_puck_pkg;

  // Display and object geometry (defaults for the module parameters)
  localparam int DEF_WIDTH       = 96;
  localparam int DEF_HEIGHT      = 64;
  localparam int DEF_PADDLE_H    = 20;
  localparam int DEF_PADDLE_W    = 3;
  localparam int DEF_PUCK_R      = 1;

  // Game sequencing
  localparam int DEF_SERVE_TICKS = 30;
  localparam int DEF_GOAL_TICKS  = 20;
  localparam int DEF_WIN_SCORE   = 7;

  // RGB565 colours
  localparam logic [15:0] DEF_PUCK_COL  = 16'hFFFF;
  localparam logic [15:0] DEF_FLASH_COL = 16'hFFE0;

  // Game state encodings, shared with the paddle block
  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_GOAL  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // Serve/goal tick counter width; bit 2 doubles as the goal flash phase
  localparam int CNT_W = 8;

  // Score increment that sticks at the winning score
  function automatic logic [3:0] satInc(input logic [3:0] score, input logic [3:0] limit);
    return (score >= limit) ? limit : score + 4'd1;
  endfunction

endpackage

// File: rtl/air_hockey_puck_collide.sv
// rtl/air_hockey_puck_collide.sv - combinational one-tick puck step: walls, paddles, goal lines
module air_hockey_puck_collide
  import air_hockey_puck_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int PADDLE_H = DEF_PADDLE_H,
  parameter int PADDLE_W = DEF_PADDLE_W,
  parameter int PUCK_R   = DEF_PUCK_R
) (
  input  logic [6:0] puckX,
  input  logic [6:0] puckY,
  input  logic       dxNeg,
  input  logic       dyNeg,
  input  logic       dyMag,
  input  logic [6:0] userPaddleX,
  input  logic [6:0] userPaddleY,
  input  logic [6:0] audioPaddleX,
  input  logic [6:0] audioPaddleY,
  output logic [6:0] nextX,
  output logic [6:0] nextY,
  output logic       nextDxNeg,
  output logic       nextDyNeg,
  output logic       nextDyMag,
  output logic       hitUser,
  output logic       hitAudio,
  output logic       goalUser,
  output logic       goalAudio
);

  // All geometry compares are done in 10-bit signed so edges below 0 behave
  localparam logic signed [9:0] R      = 10'(PUCK_R);
  localparam logic signed [9:0] HALF_H = 10'(PADDLE_H / 2);
  localparam logic signed [9:0] HALF_W = 10'(PADDLE_W / 2);
  localparam logic signed [9:0] Y_MAX  = 10'(HEIGHT - 1);
  localparam logic signed [9:0] X_MAX  = 10'(WIDTH - 1);
  localparam logic [6:0]        Y_LO   = 7'(PUCK_R);
  localparam logic [6:0]        Y_HI   = 7'(HEIGHT - 1 - PUCK_R);

  logic signed [7:0] stepX, stepY;
  logic signed [9:0] sx, sy, pyS, ux, uy, ax, ay;
  logic signed [9:0] offU, offA, absU, absA, off;
  logic [6:0]        yRes;
  logic              wallHit, hit;

  // Raw step: 8-bit signed pos+d so a step past 0 or 127 cannot wrap
  always_comb begin
    stepX = $signed({1'b0, puckX}) + (dxNeg ? -8'sd1 : 8'sd1);
    stepY = $signed({1'b0, puckY}) + (dyMag ? (dyNeg ? -8'sd1 : 8'sd1) : 8'sd0);
  end

  assign sx  = {{2{stepX[7]}}, stepX};
  assign sy  = {{2{stepY[7]}}, stepY};
  assign pyS = {3'b000, puckY};
  assign ux  = {3'b000, userPaddleX};
  assign uy  = {3'b000, userPaddleY};
  assign ax  = {3'b000, audioPaddleX};
  assign ay  = {3'b000, audioPaddleY};

  // Vertical offset of the puck from each paddle centre, taken before the move
  always_comb begin
    offU = pyS - uy;
    offA = pyS - ay;
    absU = offU[9] ? -offU : offU;
    absA = offA[9] ? -offA : offA;
  end

  // Top/bottom wall: reflect and clamp the puck edge onto the wall row
  always_comb begin
    wallHit = 1'b0;
    yRes    = sy[6:0];
    if (sy - R < 10'sd0) begin
      wallHit = 1'b1;
      yRes    = Y_LO;
    end else if (sy + R > Y_MAX) begin
      wallHit = 1'b1;
      yRes    = Y_HI;
    end
  end

  // Paddle overlap (only the paddle the puck is heading toward) and raw goal lines
  always_comb begin
    hitUser   = dxNeg && (sx - R <= ux + HALF_W) && (sx + R >= ux - HALF_W)
                && (absU <= HALF_H + R);
    hitAudio  = !dxNeg && (sx + R >= ax - HALF_W) && (sx - R <= ax + HALF_W)
                && (absA <= HALF_H + R);
    goalAudio = (sx - R <= 10'sd0);
    goalUser  = (sx + R >= X_MAX);
  end

  // Resolve the step: paddle reverses X and steers Y unless a wall flip already owns dy
  always_comb begin
    hit       = hitUser | hitAudio;
    off       = hitUser ? offU : offA;
    nextDxNeg = hit ? ~dxNeg : dxNeg;
    nextDyNeg = dyNeg ^ wallHit;
    nextDyMag = dyMag;
    if (hit && !wallHit) begin
      if (off < -10'sd3) begin
        nextDyNeg = 1'b1;
        nextDyMag = 1'b1;
      end else if (off > 10'sd3) begin
        nextDyNeg = 1'b0;
        nextDyMag = 1'b1;
      end
    end
    nextX = hit ? puckX : sx[6:0];
    nextY = yRes;
  end

endmodule

// File: rtl/air_hockey_puck.sv
// rtl/air_hockey_puck.sv - puck physics, scoring FSM and puck pixel compare
module air_hockey_puck
  import air_hockey_puck_pkg::*;
#(
  parameter int          WIDTH       = DEF_WIDTH,
  parameter int          HEIGHT      = DEF_HEIGHT,
  parameter int          PADDLE_H    = DEF_PADDLE_H,
  parameter int          PADDLE_W    = DEF_PADDLE_W,
  parameter int          PUCK_R      = DEF_PUCK_R,
  parameter int          SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int          GOAL_TICKS  = DEF_GOAL_TICKS,
  parameter int          WIN_SCORE   = DEF_WIN_SCORE,
  parameter logic [15:0] PUCK_COL    = DEF_PUCK_COL,
  parameter logic [15:0] FLASH_COL   = DEF_FLASH_COL
) (
  input  logic        clkPuck,
  input  logic        rst,
  input  logic        sw15,
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  input  logic [6:0]  userPaddleX,
  input  logic [6:0]  userPaddleY,
  input  logic [6:0]  audioPaddleX,
  input  logic [6:0]  audioPaddleY,
  output logic [6:0]  puckX,
  output logic [6:0]  puckY,
  output logic        puckAppear,
  output logic [15:0] puck_col,
  output logic [3:0]  userScore,
  output logic [3:0]  audioScore,
  output logic        goalPulse,
  output logic        gameOver
);

  localparam logic [6:0]       CX         = 7'(WIDTH / 2);
  localparam logic [6:0]       CY         = 7'(HEIGHT / 2);
  localparam logic [7:0]       R8         = 8'(PUCK_R);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0] GOAL_LAST  = CNT_W'(GOAL_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  logic             dxNeg, dyNeg, dyMag;

  logic [6:0] nextX, nextY;
  logic       nextDxNeg, nextDyNeg, nextDyMag;
  logic       hitUser, hitAudio, goalUser, goalAudio;
  logic       paddleHit, goalNow, userGoalNow;

  air_hockey_puck_collide #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .PADDLE_H (PADDLE_H),
    .PADDLE_W (PADDLE_W),
    .PUCK_R   (PUCK_R)
  ) u_collide (
    .puckX        (puckX),
    .puckY        (puckY),
    .dxNeg        (dxNeg),
    .dyNeg        (dyNeg),
    .dyMag        (dyMag),
    .userPaddleX  (userPaddleX),
    .userPaddleY  (userPaddleY),
    .audioPaddleX (audioPaddleX),
    .audioPaddleY (audioPaddleY),
    .nextX        (nextX),
    .nextY        (nextY),
    .nextDxNeg    (nextDxNeg),
    .nextDyNeg    (nextDyNeg),
    .nextDyMag    (nextDyMag),
    .hitUser      (hitUser),
    .hitAudio     (hitAudio),
    .goalUser     (goalUser),
    .goalAudio    (goalAudio)
  );

  // A paddle return on the goal line saves the goal
  always_comb begin
    paddleHit   = hitUser | hitAudio;
    goalNow     = (goalUser | goalAudio) & ~paddleHit;
    userGoalNow = goalUser & ~paddleHit;
  end

  // Game FSM: serve hold, play stepping, goal flash, game over
  always_ff @(posedge clkPuck or negedge rst) begin
    if (!rst) begin
      state      <= ST_SERVE;
      counter    <= '0;
      puckX      <= CX;
      puckY      <= CY;
      dxNeg      <= 1'b0;
      dyNeg      <= 1'b0;
      dyMag      <= 1'b1;
      userScore  <= 4'd0;
      audioScore <= 4'd0;
      goalPulse  <= 1'b0;
    end else if (!sw15) begin
      state      <= ST_SERVE;
      counter    <= '0;
      puckX      <= CX;
      puckY      <= CY;
      dxNeg      <= 1'b0;
      dyNeg      <= 1'b0;
      dyMag      <= 1'b1;
      userScore  <= 4'd0;
      audioScore <= 4'd0;
      goalPulse  <= 1'b0;
    end else begin
      case (state)
        ST_SERVE: begin
          // Every serve launches diagonally downward; dx was aimed at the conceding side
          puckX     <= CX;
          puckY     <= CY;
          dyNeg     <= 1'b0;
          dyMag     <= 1'b1;
          goalPulse <= 1'b0;
          if (counter == SERVE_LAST) begin
            state   <= ST_PLAY;
            counter <= '0;
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        ST_PLAY: begin
          puckX     <= nextX;
          puckY     <= nextY;
          dxNeg     <= nextDxNeg;
          dyNeg     <= nextDyNeg;
          dyMag     <= nextDyMag;
          goalPulse <= goalNow;
          if (goalNow) begin
            state   <= ST_GOAL;
            counter <= '0;
            if (userGoalNow) begin
              userScore <= satInc(userScore, WIN);
              dxNeg     <= 1'b0;
            end else begin
              audioScore <= satInc(audioScore, WIN);
              dxNeg      <= 1'b1;
            end
          end
        end
        ST_GOAL: begin
          goalPulse <= 1'b0;
          if (counter == GOAL_LAST) begin
            counter <= '0;
            puckX   <= CX;
            puckY   <= CY;
            state   <= ((userScore == WIN) || (audioScore == WIN)) ? ST_OVER : ST_SERVE;
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        default: begin
          goalPulse <= 1'b0;
          puckX     <= CX;
          puckY     <= CY;
        end
      endcase
    end
  end

  // Pixel compare against the (2R+1)x(2R+1) puck square, plus flash colour
  always_comb begin
    puckAppear = ({1'b0, x} + R8 >= {1'b0, puckX}) && ({1'b0, x} <= {1'b0, puckX} + R8) &&
                 ({1'b0, y} + R8 >= {1'b0, puckY}) && ({1'b0, y} <= {1'b0, puckY} + R8);
    puck_col   = ((state == ST_GOAL) && counter[2]) ? FLASH_COL : PUCK_COL;
  end

  assign gameOver = (state == ST_OVER);

endmodule

// File: tb/tb_air_hockey_puck.sv
// tb/tb_air_hockey_puck.sv - scoreboard bench for air_hockey_puck
module tb_air_hockey_puck;

  logic        clkPuck = 1'b0;
  logic        rst;
  logic        sw15;
  logic [6:0]  x, y;
  logic [6:0]  userPaddleX, userPaddleY, audioPaddleX, audioPaddleY;
  logic [6:0]  puckX, puckY;
  logic        puckAppear;
  logic [15:0] puck_col;
  logic [3:0]  userScore, audioScore;
  logic        goalPulse, gameOver;

  air_hockey_puck dut (
    .clkPuck      (clkPuck),
    .rst          (rst),
    .sw15         (sw15),
    .x            (x),
    .y            (y),
    .userPaddleX  (userPaddleX),
    .userPaddleY  (userPaddleY),
    .audioPaddleX (audioPaddleX),
    .audioPaddleY (audioPaddleY),
    .puckX        (puckX),
    .puckY        (puckY),
    .puckAppear   (puckAppear),
    .puck_col     (puck_col),
    .userScore    (userScore),
    .audioScore   (audioScore),
    .goalPulse    (goalPulse),
    .gameOver     (gameOver)
  );

  always #5 clkPuck = ~clkPuck;

  int nCompared   = 0;
  int nMismatched = 0;
  int tickNo      = 0;
  int pulses      = 0;
  bit trackUser   = 0;
  bit trackAudio  = 0;
  logic [63:0] sbq[$];

  // Reference game state
  int   mState, mCnt, mPx, mPy, mVx, mVy, mUs, mAs;
  logic mGp;

  // Hand-derived positions for the opening rally (serve, wall bounce, paddle return, corner)
  int         dirEdge[10] = '{30, 31, 60, 61, 62, 71, 72, 73, 123, 124};
  logic [13:0] dirPos[10] = '{{7'd48, 7'd32}, {7'd49, 7'd33}, {7'd78, 7'd62}, {7'd79, 7'd62},
                              {7'd80, 7'd61}, {7'd89, 7'd52}, {7'd89, 7'd51}, {7'd88, 7'd50},
                              {7'd39, 7'd1},  {7'd40, 7'd2}};

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h (tick %0d)", tag, got, exp, tickNo);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic modelReset();
    mState = 0; mCnt = 0; mPx = 48; mPy = 32; mVx = 1; mVy = 1;
    mUs = 0; mAs = 0; mGp = 1'b0;
  endtask

  task automatic modelTick();
    int nx, ny, nvx, nvy, off, uX, uY, aX, aY;
    bit wall, hit;
    if (!sw15) begin
      modelReset();
      return;
    end
    uX = int'(userPaddleX);  uY = int'(userPaddleY);
    aX = int'(audioPaddleX); aY = int'(audioPaddleY);
    case (mState)
      0: begin
        mGp = 1'b0; mPx = 48; mPy = 32; mVy = 1;
        if (mCnt == 29) begin mState = 1; mCnt = 0; end
        else mCnt++;
      end
      1: begin
        mGp = 1'b0;
        nx = mPx + mVx; ny = mPy + mVy; nvx = mVx; nvy = mVy;
        wall = 0; hit = 0; off = 0;
        if (ny - 1 < 0) begin ny = 1; nvy = -mVy; wall = 1; end
        else if (ny + 1 > 63) begin ny = 62; nvy = -mVy; wall = 1; end
        if (mVx < 0 && nx - 1 <= uX + 1 && nx + 1 >= uX - 1 && iabs(mPy - uY) <= 11) begin
          hit = 1; off = mPy - uY;
        end
        if (mVx > 0 && nx + 1 >= aX - 1 && nx - 1 <= aX + 1 && iabs(mPy - aY) <= 11) begin
          hit = 1; off = mPy - aY;
        end
        if (hit) begin
          nvx = -mVx; nx = mPx;
          if (!wall) begin
            if (off < -3) nvy = -1;
            else if (off > 3) nvy = 1;
          end
        end else if (nx + 1 >= 95) begin
          mUs = (mUs < 7) ? mUs + 1 : 7; mGp = 1'b1; mState = 2; mCnt = 0; nvx = 1;
        end else if (nx - 1 <= 0) begin
          mAs = (mAs < 7) ? mAs + 1 : 7; mGp = 1'b1; mState = 2; mCnt = 0; nvx = -1;
        end
        mPx = nx; mPy = ny; mVx = nvx; mVy = nvy;
      end
      2: begin
        mGp = 1'b0;
        if (mCnt == 19) begin
          mCnt = 0; mPx = 48; mPy = 32;
          mState = (mUs == 7 || mAs == 7) ? 3 : 0;
        end else mCnt++;
      end
      default: begin
        mGp = 1'b0; mPx = 48; mPy = 32;
      end
    endcase
  endtask

  function automatic logic [63:0] modelWord();
    logic        appear, over;
    logic [15:0] col;
    appear = (iabs(int'(x) - mPx) <= 1) && (iabs(int'(y) - mPy) <= 1);
    over   = (mState == 3);
    col    = (mState == 2 && (mCnt & 4) != 0) ? 16'hFFE0 : 16'hFFFF;
    return {23'd0, 7'(mPx), 7'(mPy), 4'(mUs), 4'(mAs), mGp, over, appear, col};
  endfunction

  function automatic logic [63:0] dutWord();
    return {23'd0, puckX, puckY, userScore, audioScore, goalPulse, gameOver, puckAppear, puck_col};
  endfunction

  // Drive one tick of stimulus, push the expected outputs, compare after the edge
  task automatic tick();
    logic [63:0] e;
    int          offs;
    offs = ((tickNo / 7) % 3 == 0) ? 0 : (((tickNo / 7) % 3 == 1) ? 6 : -5);
    if (trackUser)  userPaddleY  = 7'(clampi(mPy + offs, 0, 63));
    if (trackAudio) audioPaddleY = 7'(clampi(mPy + offs, 0, 63));
    modelTick();
    x = 7'(clampi(mPx + int'($urandom_range(0, 4)) - 2, 0, 127));
    y = 7'(clampi(mPy + int'($urandom_range(0, 4)) - 2, 0, 127));
    sbq.push_back(modelWord());
    @(posedge clkPuck);
    #1;
    tickNo++;
    e = sbq.pop_front();
    checkVal("tick", dutWord(), e);
  endtask

  initial begin
    rst = 1'b0; sw15 = 1'b1; x = 7'd0; y = 7'd0;
    userPaddleX = 7'd36; userPaddleY = 7'd8;
    audioPaddleX = 7'd92; audioPaddleY = 7'd50;
    modelReset();
    repeat (2) @(posedge clkPuck);
    #1;
    checkVal("rstPos",   64'({puckX, puckY}), 64'({7'd48, 7'd32}));
    checkVal("rstScore", 64'({userScore, audioScore}), 64'd0);
    checkVal("rstFlags", 64'({goalPulse, gameOver}), 64'd0);
    checkVal("rstCol",   64'(puck_col), 64'hFFFF);
    @(negedge clkPuck);
    rst = 1'b1;

    // Opening rally: serve, bottom wall, audio paddle return, wall+user paddle corner
    for (int i = 0; i < 130; i++) begin
      tick();
      for (int k = 0; k < 10; k++)
        if (tickNo == dirEdge[k]) checkVal("dirPos", 64'({puckX, puckY}), 64'(dirPos[k]));
    end

    // User defends every time, audio paddle is out of reach: user plays to the win
    userPaddleX = 7'd2; audioPaddleX = 7'd127; audioPaddleY = 7'd10; trackUser = 1;
    for (int i = 0; i < 3000 && mState != 3; i++) begin
      tick();
      if (goalPulse) pulses++;
    end
    checkVal("overReached", 64'(gameOver), 64'd1);
    checkVal("winScore",    64'(userScore), 64'd7);
    checkVal("goalPulses",  64'(pulses), 64'd7);
    for (int i = 0; i < 100; i++) tick();
    checkVal("overHold", 64'({gameOver, puckX, puckY}), 64'({1'b1, 7'd48, 7'd32}));

    // Game enable low clears everything in one tick
    sw15 = 1'b0;
    tick();
    checkVal("sw15Clear", 64'({userScore, audioScore, gameOver}), 64'd0);
    sw15 = 1'b1;

    // Audio defends, user paddle out of reach: audio scores, next serve heads left
    trackUser = 0; userPaddleX = 7'd127; userPaddleY = 7'd32;
    audioPaddleX = 7'd92; trackAudio = 1;
    for (int i = 0; i < 1000 && !(mAs == 1 && mState == 1); i++) tick();
    tick();
    checkVal("serveDir", 64'({puckX, puckY}), 64'({7'd47, 7'd33}));
    repeat (5) tick();

    // Asynchronous reset between clock edges mid-play
    #3;
    rst = 1'b0;
    #1;
    checkVal("asyncRst", 64'({puckX, puckY, userScore, audioScore, goalPulse, gameOver}),
             64'({7'd48, 7'd32, 4'd0, 4'd0, 1'b0, 1'b0}));
    modelReset();
    @(negedge clkPuck);
    rst = 1'b1;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
